noc_packet_receiver: RTL and testbench



---
 rtl/noc_packet_receiver.sv | 231 +++++++++++++++++++++++
 tb/tb_noc_packet_receiver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_receiver.sv
// NoC ejection endpoint: parses header/data/tail flits, queues local data flits, pulses pkt_done/pkt_err per packet.
// Payload visible 1 cycle after accept; receive_ready drops while the FIFO is full. NOC_RX_STATS_EN adds packet/error counters.
module noc_packet_receiver #(
  parameter int DATA_W     = 64,
  parameter int ID_X_W     = 4,
  parameter int ID_Y_W     = 4,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              receive_valid,
  output logic              receive_ready,
  input  logic [DATA_W-1:0] receive_flit,
  input  logic              receive_is_header,
  input  logic              receive_is_tail,
  output logic              payload_valid,
  input  logic              payload_ready,
  output logic [DATA_W-1:0] payload_data,
  output logic              payload_last,
  output logic              pkt_done,
  output logic [ID_X_W-1:0] pkt_src_x,
  output logic [ID_Y_W-1:0] pkt_src_y,
  output logic [1:0]        pkt_type,
  output logic [4:0]        pkt_err
`ifdef NOC_RX_STATS_EN
  ,
  output logic [15:0]       stat_pkt_cnt,
  output logic [15:0]       stat_err_cnt
`endif
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = LEN_W + 1;
  // Field LSB positions, packed MSB-first from the top of the flit.
  localparam int P_MH  = DATA_W - 4;
  localparam int P_SX  = P_MH - ID_X_W;
  localparam int P_SY  = P_SX - ID_Y_W;
  localparam int P_DX  = P_SY - ID_X_W;
  localparam int P_DY  = P_DX - ID_Y_W;
  localparam int P_TY  = P_DY - 2;
  localparam int P_LN  = P_TY - 4 - LEN_W;
  localparam int P_ME  = P_LN - 4;

  typedef enum logic {IDLE, DATA} state_e;

  state_e              state_q, state_d;
  logic [ID_X_W-1:0]   src_x_q, src_x_d, dst_x_q, dst_x_d;
  logic [ID_Y_W-1:0]   src_y_q, src_y_d, dst_y_q, dst_y_d;
  logic [1:0]          type_q, type_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [4:0]          err_q, err_d;
  logic [DATA_W:0]     mem_q [FIFO_DEPTH];
  logic [DATA_W:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;

  logic [3:0]          f_mh, f_me;
  logic [ID_X_W-1:0]   f_sx, f_dx;
  logic [ID_Y_W-1:0]   f_sy, f_dy;
  logic [1:0]          f_ty;
  logic [LEN_W-1:0]    f_ln;
  logic                acc, is_hdr, is_tail, is_data, hdr_ok, tail_bad;
  logic                dst_match, cnt_bad, fifo_full, push, pop, push_last;

  assign f_mh = receive_flit[P_MH +: 4];
  assign f_sx = receive_flit[P_SX +: ID_X_W];
  assign f_sy = receive_flit[P_SY +: ID_Y_W];
  assign f_dx = receive_flit[P_DX +: ID_X_W];
  assign f_dy = receive_flit[P_DY +: ID_Y_W];
  assign f_ty = receive_flit[P_TY +: 2];
  assign f_ln = receive_flit[P_LN +: LEN_W];
  assign f_me = receive_flit[P_ME +: 4];

  assign fifo_full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign receive_ready = (state_q == IDLE) ? 1'b1 : !fifo_full;
  assign acc           = receive_valid && receive_ready;
  assign is_hdr        = acc && receive_is_header;
  assign is_tail       = acc && !receive_is_header && receive_is_tail;
  assign is_data       = acc && !receive_is_header && !receive_is_tail;
  assign hdr_ok        = (f_mh == 4'hA) && (f_me == 4'h5);
  assign dst_match     = (dst_x_q == ID_X_W'(MY_X)) && (dst_y_q == ID_Y_W'(MY_Y));
  assign cnt_bad       = (cnt_q != ({1'b0, len_q} + CNT_W'(1)));
  assign push_last     = (cnt_q == {1'b0, len_q});
  assign tail_bad      = (f_mh != 4'hC) || (f_me != 4'h3) || (f_sx != src_x_q) ||
                         (f_sy != src_y_q) || (f_dx != dst_x_q) || (f_dy != dst_y_q) ||
                         (f_ty != type_q);

  always_comb begin
    state_d = state_q;
    src_x_d = src_x_q;
    src_y_d = src_y_q;
    dst_x_d = dst_x_q;
    dst_y_d = dst_y_q;
    type_d  = type_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 5'b0;
    push    = 1'b0;

    if (state_q == DATA) begin
      if (is_data) begin
        push = dst_match;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
      if (is_tail) begin
        state_d  = IDLE;
        done_d   = 1'b1;
        err_d[1] = !dst_match;
        err_d[2] = cnt_bad;
        err_d[3] = tail_bad;
      end
      // A header inside a packet truncates it; the new header is then handled below.
      if (is_hdr) begin
        done_d   = 1'b1;
        err_d[4] = 1'b1;
        err_d[1] = !dst_match;
        err_d[2] = cnt_bad;
      end
    end

    if (is_hdr) begin
      if (hdr_ok) begin
        src_x_d = f_sx;
        src_y_d = f_sy;
        dst_x_d = f_dx;
        dst_y_d = f_dy;
        type_d  = f_ty;
        len_d   = f_ln;
        cnt_d   = '0;
        state_d = DATA;
      end else begin
        done_d   = 1'b1;
        err_d[0] = 1'b1;
        state_d  = IDLE;
      end
    end
  end

  assign pop = payload_valid && payload_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {push_last, receive_flit};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q  <= IDLE;
      src_x_q  <= '0;
      src_y_q  <= '0;
      dst_x_q  <= '0;
      dst_y_q  <= '0;
      type_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      src_x_q  <= src_x_d;
      src_y_q  <= src_y_d;
      dst_x_q  <= dst_x_d;
      dst_y_q  <= dst_y_d;
      type_q   <= type_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign payload_valid = (count_q != '0);
  assign payload_data  = mem_q[rd_ptr_q][DATA_W-1:0];
  assign payload_last  = mem_q[rd_ptr_q][DATA_W] && payload_valid;
  assign pkt_done      = done_q;
  assign pkt_err       = err_q;
  assign pkt_src_x     = src_x_q;
  assign pkt_src_y     = src_y_q;
  assign pkt_type      = type_q;

`ifdef NOC_RX_STATS_EN
  logic [15:0] stat_pkt_q, stat_pkt_d, stat_err_q, stat_err_d;

  always_comb begin
    stat_pkt_d = stat_pkt_q;
    stat_err_d = stat_err_q;
    if (done_q && (stat_pkt_q != 16'hFFFF)) stat_pkt_d = stat_pkt_q + 16'd1;
    if (done_q && (err_q != 5'b0) && (stat_err_q != 16'hFFFF)) stat_err_d = stat_err_q + 16'd1;
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      stat_pkt_q <= '0;
      stat_err_q <= '0;
    end else begin
      stat_pkt_q <= stat_pkt_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_pkt_cnt = stat_pkt_q;
  assign stat_err_cnt = stat_err_q;
`endif

endmodule

// File: tb/tb_noc_packet_receiver.sv
// Directed bench for noc_packet_receiver with MY=(1,2), FIFO_DEPTH=4; payload beats and completions are scoreboarded.
module tb_noc_packet_receiver;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        receive_valid = 1'b0;
  logic        receive_ready;
  logic [63:0] receive_flit = '0;
  logic        receive_is_header = 1'b0;
  logic        receive_is_tail = 1'b0;
  logic        payload_valid;
  logic        payload_ready = 1'b1;
  logic [63:0] payload_data;
  logic        payload_last;
  logic        pkt_done;
  logic [3:0]  pkt_src_x;
  logic [3:0]  pkt_src_y;
  logic [1:0]  pkt_type;
  logic [4:0]  pkt_err;
`ifdef NOC_RX_STATS_EN
  logic [15:0] stat_pkt_cnt;
  logic [15:0] stat_err_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [64:0] exp_pay[$];
  logic [14:0] exp_done[$];

  noc_packet_receiver #(
    .DATA_W(64), .ID_X_W(4), .ID_Y_W(4), .MY_X(1), .MY_Y(2), .LEN_W(8), .FIFO_DEPTH(4)
  ) dut (
    .noc_clk(noc_clk),
    .noc_rst_n(noc_rst_n),
    .receive_valid(receive_valid),
    .receive_ready(receive_ready),
    .receive_flit(receive_flit),
    .receive_is_header(receive_is_header),
    .receive_is_tail(receive_is_tail),
    .payload_valid(payload_valid),
    .payload_ready(payload_ready),
    .payload_data(payload_data),
    .payload_last(payload_last),
    .pkt_done(pkt_done),
    .pkt_src_x(pkt_src_x),
    .pkt_src_y(pkt_src_y),
    .pkt_type(pkt_type),
    .pkt_err(pkt_err)
`ifdef NOC_RX_STATS_EN
    ,
    .stat_pkt_cnt(stat_pkt_cnt),
    .stat_err_cnt(stat_err_cnt)
`endif
  );

  always #5 noc_clk = ~noc_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] flit(input logic [3:0] mh, input logic [3:0] sx, input logic [3:0] sy,
                                       input logic [3:0] dx, input logic [3:0] dy, input logic [1:0] ty,
                                       input logic [7:0] ln, input logic [3:0] me);
    return {mh, sx, sy, dx, dy, ty, 4'h0, ln, me, 26'h0};
  endfunction

  task automatic send(input logic [63:0] f, input logic h, input logic t);
    int n = 0;
    receive_flit = f;
    receive_is_header = h;
    receive_is_tail = t;
    receive_valid = 1'b1;
    @(negedge noc_clk);
    while (!receive_ready && n < 50) begin
      @(negedge noc_clk);
      n++;
    end
    if (!receive_ready) chk("accept_timeout", {63'b0, receive_ready}, 64'd1);
    else @(posedge noc_clk);
    #1;
    receive_valid = 1'b0;
    receive_is_header = 1'b0;
    receive_is_tail = 1'b0;
  endtask

  task automatic expect_done(input logic [3:0] x, input logic [3:0] y, input logic [1:0] t, input logic [4:0] e);
    exp_done.push_back({e, t, y, x});
  endtask

  always @(negedge noc_clk) begin
    if (noc_rst_n && payload_valid && payload_ready) begin
      if (exp_pay.size() == 0) begin
        chk("unexpected_payload", payload_data, 64'hDEAD);
      end else begin
        logic [64:0] e;
        e = exp_pay.pop_front();
        chk("payload_data", payload_data, e[63:0]);
        chk("payload_last", {63'b0, payload_last}, {63'b0, e[64]});
      end
    end
  end

  always @(negedge noc_clk) begin
    if (pkt_done) begin
      if (exp_done.size() == 0) begin
        chk("unexpected_pkt_done", {59'b0, pkt_err}, 64'h100);
      end else begin
        logic [14:0] e;
        e = exp_done.pop_front();
        chk("pkt_src_x", {60'b0, pkt_src_x}, {60'b0, e[3:0]});
        chk("pkt_src_y", {60'b0, pkt_src_y}, {60'b0, e[7:4]});
        chk("pkt_type", {62'b0, pkt_type}, {62'b0, e[9:8]});
        chk("pkt_err", {59'b0, pkt_err}, {59'b0, e[14:10]});
      end
    end
  end

  initial begin
    logic [63:0] d;
    // Reset state
    repeat (3) @(posedge noc_clk);
    #1;
    chk("rst_payload_valid", {63'b0, payload_valid}, 64'd0);
    chk("rst_payload_last", {63'b0, payload_last}, 64'd0);
    chk("rst_pkt_done", {63'b0, pkt_done}, 64'd0);
    chk("rst_pkt_err", {59'b0, pkt_err}, 64'd0);
    chk("rst_src", {56'b0, pkt_src_x, pkt_src_y}, 64'd0);
    chk("rst_type", {62'b0, pkt_type}, 64'd0);
    chk("rst_receive_ready", {63'b0, receive_ready}, 64'd1);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;

    // 1: single-beat packet, latency check
    send(flit(4'hA, 4'h0, 4'h0, 4'h1, 4'h2, 2'd1, 8'd0, 4'h5), 1'b1, 1'b0);
    exp_pay.push_back({1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    chk("latency_payload_valid", {63'b0, payload_valid}, 64'd1);
    expect_done(4'h0, 4'h0, 2'd1, 5'b00000);
    send(flit(4'hC, 4'h0, 4'h0, 4'h1, 4'h2, 2'd1, 8'd0, 4'h3), 1'b0, 1'b1);
    repeat (3) @(posedge noc_clk);
    #1;

    // Bad header marker in IDLE, then a stray data flit that must be dropped
    expect_done(4'h0, 4'h0, 2'd1, 5'b00001);
    send(flit(4'h7, 4'h9, 4'h9, 4'h1, 4'h2, 2'd3, 8'd0, 4'h5), 1'b1, 1'b0);
    send(64'h1234, 1'b0, 1'b0);
    repeat (3) @(posedge noc_clk);
    #1;

    // 2: FIFO fills, backpressure holds the tail, then drains in order
    payload_ready = 1'b0;
    send(flit(4'hA, 4'h2, 4'h1, 4'h1, 4'h2, 2'd2, 8'd3, 4'h5), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      d = 64'hA5A5_0000_0000_0000 + 64'(i);
      exp_pay.push_back({(i == 3), d});
      send(d, 1'b0, 1'b0);
    end
    chk("full_receive_ready", {63'b0, receive_ready}, 64'd0);
    receive_flit = flit(4'hC, 4'h2, 4'h1, 4'h1, 4'h2, 2'd2, 8'd3, 4'h3);
    receive_is_tail = 1'b1;
    receive_valid = 1'b1;
    repeat (3) @(posedge noc_clk);
    #1;
    chk("held_receive_ready", {63'b0, receive_ready}, 64'd0);
    expect_done(4'h2, 4'h1, 2'd2, 5'b00000);
    payload_ready = 1'b1;
    send(flit(4'hC, 4'h2, 4'h1, 4'h1, 4'h2, 2'd2, 8'd3, 4'h3), 1'b0, 1'b1);
    repeat (6) @(posedge noc_clk);
    #1;

    // 3: destination mismatch, no payload
    send(flit(4'hA, 4'h1, 4'h1, 4'h3, 4'h3, 2'd0, 8'd0, 4'h5), 1'b1, 1'b0);
    send(64'h5555, 1'b0, 1'b0);
    expect_done(4'h1, 4'h1, 2'd0, 5'b00010);
    send(flit(4'hC, 4'h1, 4'h1, 4'h3, 4'h3, 2'd0, 8'd0, 4'h3), 1'b0, 1'b1);
    repeat (3) @(posedge noc_clk);
    #1;

    // 4a: short packet (len=2, one flit)
    send(flit(4'hA, 4'h2, 4'h2, 4'h1, 4'h2, 2'd3, 8'd2, 4'h5), 1'b1, 1'b0);
    exp_pay.push_back({1'b0, 64'h0000_0000_0000_0042});
    send(64'h42, 1'b0, 1'b0);
    expect_done(4'h2, 4'h2, 2'd3, 5'b00100);
    send(flit(4'hC, 4'h2, 4'h2, 4'h1, 4'h2, 2'd3, 8'd2, 4'h3), 1'b0, 1'b1);
    repeat (3) @(posedge noc_clk);
    #1;

    // 4b: bad tail marker
    send(flit(4'hA, 4'h3, 4'h0, 4'h1, 4'h2, 2'd1, 8'd0, 4'h5), 1'b1, 1'b0);
    exp_pay.push_back({1'b1, 64'h0000_0000_0000_0077});
    send(64'h77, 1'b0, 1'b0);
    expect_done(4'h3, 4'h0, 2'd1, 5'b01000);
    send(flit(4'hB, 4'h3, 4'h0, 4'h1, 4'h2, 2'd1, 8'd0, 4'h3), 1'b0, 1'b1);
    repeat (3) @(posedge noc_clk);
    #1;

    // 5: truncation by a new header, then the new packet completes cleanly
    send(flit(4'hA, 4'h4, 4'h4, 4'h1, 4'h2, 2'd0, 8'd0, 4'h5), 1'b1, 1'b0);
    exp_pay.push_back({1'b1, 64'h0000_0000_0000_0011});
    send(64'h11, 1'b0, 1'b0);
    expect_done(4'h5, 4'h6, 2'd2, 5'b10000);
    send(flit(4'hA, 4'h5, 4'h6, 4'h1, 4'h2, 2'd2, 8'd0, 4'h5), 1'b1, 1'b0);
    exp_pay.push_back({1'b1, 64'h0000_0000_0000_0022});
    send(64'h22, 1'b0, 1'b0);
    expect_done(4'h5, 4'h6, 2'd2, 5'b00000);
    send(flit(4'hC, 4'h5, 4'h6, 4'h1, 4'h2, 2'd2, 8'd0, 4'h3), 1'b0, 1'b1);
    repeat (3) @(posedge noc_clk);
    #1;
`ifdef NOC_RX_STATS_EN
    chk("stat_pkt_cnt", {48'b0, stat_pkt_cnt}, 64'd8);
    chk("stat_err_cnt", {48'b0, stat_err_cnt}, 64'd5);
`endif

    // 6: reset in the middle of a packet with two flits queued
    payload_ready = 1'b0;
    send(flit(4'hA, 4'h7, 4'h7, 4'h1, 4'h2, 2'd1, 8'd3, 4'h5), 1'b1, 1'b0);
    send(64'hAA, 1'b0, 1'b0);
    send(64'hBB, 1'b0, 1'b0);
    chk("pre_rst_payload_valid", {63'b0, payload_valid}, 64'd1);
    #2;
    noc_rst_n = 1'b0;
    #1;
    chk("mid_rst_payload_valid", {63'b0, payload_valid}, 64'd0);
    chk("mid_rst_receive_ready", {63'b0, receive_ready}, 64'd1);
    chk("mid_rst_pkt_done", {63'b0, pkt_done}, 64'd0);
`ifdef NOC_RX_STATS_EN
    chk("rst_stat_pkt_cnt", {48'b0, stat_pkt_cnt}, 64'd0);
    chk("rst_stat_err_cnt", {48'b0, stat_err_cnt}, 64'd0);
`endif
    repeat (2) @(posedge noc_clk);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    payload_ready = 1'b1;
    repeat (4) @(posedge noc_clk);
    #1;
    chk("post_rst_payload_valid", {63'b0, payload_valid}, 64'd0);

    chk("payload_queue_drained", 64'(exp_pay.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
